// File: rtl/exe_pkg.sv
// Shared types and constants for the execute-to-memory decoupling buffer.
package exe_pkg;

    localparam int unsigned bitWidth = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef struct packed {
        logic [bitWidth-1:0] res;
        logic [4:0]          rd;
        logic                wb;
    } exe_entry_t;

endpackage

// File: rtl/exe_fwd_match.sv
// Forwarding lookup over age-ordered buffer entries (index 0 oldest); youngest match wins.
module exe_fwd_match
    import exe_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  exe_entry_t          entries [Depth],
    input  logic [Depth-1:0]    valid,
    input  logic [4:0]          rs,
    output logic                hit,
    output logic [bitWidth-1:0] data
);

    // Later (younger) matches overwrite earlier ones, giving youngest-first priority.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            if (valid[i] && entries[i].wb && (entries[i].rd == rs) && (rs != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[i].res;
            end
        end
    end

endmodule

// File: rtl/exe_mem_buffer.sv
// Circular FIFO between execute and memory stages with operand-forwarding lookups.
module exe_mem_buffer
    import exe_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                exe_valid_i,
    output logic                exe_ready_o,
    input  logic [bitWidth-1:0] exe_res_i,
    input  logic [4:0]          exe_rd_i,
    input  logic                exe_wb_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [bitWidth-1:0] mem_res_o,
    output logic [4:0]          mem_rd_o,
    output logic                mem_wb_o,
    input  logic [4:0]          fwd_rs1_i,
    input  logic [4:0]          fwd_rs2_i,
    output logic                fwd_rs1_hit_o,
    output logic                fwd_rs2_hit_o,
    output logic [bitWidth-1:0] fwd_rs1_data_o,
    output logic [bitWidth-1:0] fwd_rs2_data_o
);

    localparam int unsigned PTR_W = $clog2(Depth);
    localparam int unsigned CNT_W = $clog2(Depth + 1);

    exe_entry_t       entries [Depth];
    exe_entry_t       aged    [Depth];
    logic [Depth-1:0] aged_vld;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready depends only on occupancy, so no memory-side signal reaches the execute side.
    assign exe_ready_o = (count != CNT_W'(Depth));
    assign mem_valid_o = (count != '0);
    assign push        = exe_valid_i & exe_ready_o;
    assign pop         = mem_valid_o & mem_ready_i;

    assign mem_res_o = entries[rd_ptr].res;
    assign mem_rd_o  = entries[rd_ptr].rd;
    assign mem_wb_o  = entries[rd_ptr].wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                entries[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{res: exe_res_i, rd: exe_rd_i, wb: exe_wb_i};
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Rotate storage into age order (0 = head) so the matcher sees oldest-to-youngest.
    always_comb begin
        for (int i = 0; i < int'(Depth); i++) begin
            aged[i]     = entries[rd_ptr + PTR_W'(i)];
            aged_vld[i] = (CNT_W'(i) < count);
        end
    end

    exe_fwd_match #(.Depth(Depth)) u_fwd_rs1 (
        .entries (aged),
        .valid   (aged_vld),
        .rs      (fwd_rs1_i),
        .hit     (fwd_rs1_hit_o),
        .data    (fwd_rs1_data_o)
    );

    exe_fwd_match #(.Depth(Depth)) u_fwd_rs2 (
        .entries (aged),
        .valid   (aged_vld),
        .rs      (fwd_rs2_i),
        .hit     (fwd_rs2_hit_o),
        .data    (fwd_rs2_data_o)
    );

endmodule

// File: tb/tb_exe_mem_buffer.sv
// Directed bench for exe_mem_buffer with a queue-based reference model checked every cycle.
module tb_exe_mem_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        exe_valid_i;
    logic        exe_ready_o;
    logic [31:0] exe_res_i;
    logic [4:0]  exe_rd_i;
    logic        exe_wb_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_res_o;
    logic [4:0]  mem_rd_o;
    logic        mem_wb_o;
    logic [4:0]  fwd_rs1_i;
    logic [4:0]  fwd_rs2_i;
    logic        fwd_rs1_hit_o;
    logic        fwd_rs2_hit_o;
    logic [31:0] fwd_rs1_data_o;
    logic [31:0] fwd_rs2_data_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb;
    } ent_t;

    ent_t q[$];

    exe_mem_buffer #(.Depth(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .exe_valid_i    (exe_valid_i),
        .exe_ready_o    (exe_ready_o),
        .exe_res_i      (exe_res_i),
        .exe_rd_i       (exe_rd_i),
        .exe_wb_i       (exe_wb_i),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_res_o      (mem_res_o),
        .mem_rd_o       (mem_rd_o),
        .mem_wb_o       (mem_wb_o),
        .fwd_rs1_i      (fwd_rs1_i),
        .fwd_rs2_i      (fwd_rs2_i),
        .fwd_rs1_hit_o  (fwd_rs1_hit_o),
        .fwd_rs2_hit_o  (fwd_rs2_hit_o),
        .fwd_rs1_data_o (fwd_rs1_data_o),
        .fwd_rs2_data_o (fwd_rs2_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lookup: search from youngest to oldest and stop at the first match.
    function automatic void model_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'h0;
        if (rs != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].wb && q[i].rd == rs) begin
                    hit = 1'b1;
                    d   = q[i].res;
                    break;
                end
            end
        end
    endfunction

    // Reference queue update on each rising edge.
    always @(posedge clk) begin
        bit do_push;
        bit do_pop;
        if (reset || flush_i) begin
            q.delete();
        end else begin
            do_push = exe_valid_i && (q.size() < DEPTH);
            do_pop  = mem_ready_i && (q.size() > 0);
            if (do_pop) q.delete(0);
            if (do_push) q.push_back('{res: exe_res_i, rd: exe_rd_i, wb: exe_wb_i});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        h;
        logic [31:0] d;
        if (chk_en) begin
            check("mem_valid", 32'(mem_valid_o), 32'(q.size() != 0));
            check("exe_ready", 32'(exe_ready_o), 32'(q.size() != DEPTH));
            if (q.size() != 0) begin
                check("mem_res", mem_res_o, q[0].res);
                check("mem_rd", 32'(mem_rd_o), 32'(q[0].rd));
                check("mem_wb", 32'(mem_wb_o), 32'(q[0].wb));
            end
            model_lookup(fwd_rs1_i, h, d);
            check("rs1_hit", 32'(fwd_rs1_hit_o), 32'(h));
            check("rs1_data", fwd_rs1_data_o, d);
            model_lookup(fwd_rs2_i, h, d);
            check("rs2_hit", 32'(fwd_rs2_hit_o), 32'(h));
            check("rs2_data", fwd_rs2_data_o, d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] res, input logic [4:0] rd, input logic wb);
        exe_valid_i = 1'b1;
        exe_res_i   = res;
        exe_rd_i    = rd;
        exe_wb_i    = wb;
        step();
        exe_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(mem_valid_o), 32'd0);
        check({tag, "_ready"}, 32'(exe_ready_o), 32'd1);
        check({tag, "_res"}, mem_res_o, 32'd0);
        check({tag, "_rd"}, 32'(mem_rd_o), 32'd0);
        check({tag, "_wb"}, 32'(mem_wb_o), 32'd0);
        check({tag, "_hit1"}, 32'(fwd_rs1_hit_o), 32'd0);
        check({tag, "_data1"}, fwd_rs1_data_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k;
        bit  acc;
        reset       = 1'b1;
        flush_i     = 1'b0;
        exe_valid_i = 1'b0;
        exe_res_i   = '0;
        exe_rd_i    = '0;
        exe_wb_i    = 1'b0;
        mem_ready_i = 1'b0;
        fwd_rs1_i   = 5'd0;
        fwd_rs2_i   = 5'd0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check_reset_outputs("rst");

        // Fill to full with the memory stage stalled; third offer must be refused.
        step();
        offer(32'h0000_0005, 5'd3, 1'b1);
        offer(32'hFFFF_FFFF, 5'd4, 1'b1);
        offer(32'h0000_0999, 5'd9, 1'b1);
        @(negedge clk);
        check("full_ready", 32'(exe_ready_o), 32'd0);
        check("full_head_res", mem_res_o, 32'h5);
        check("full_head_rd", 32'(mem_rd_o), 32'd3);

        // Sustained traffic from full: offers advance only when accepted.
        step();
        mem_ready_i = 1'b1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            exe_valid_i = 1'b1;
            exe_res_i   = 32'h100 + 32'(k);
            exe_rd_i    = 5'(10 + k);
            exe_wb_i    = 1'b1;
            acc = exe_ready_o;
            step();
            if (acc) k++;
            if (c == 0) begin
                @(negedge clk);
                check("pop1_head", mem_res_o, 32'hFFFF_FFFF);
                check("pop1_ready", 32'(exe_ready_o), 32'd1);
            end
        end
        exe_valid_i = 1'b0;
        step();
        step();
        @(negedge clk);
        check("drained", 32'(mem_valid_o), 32'd0);
        check("accepted_cnt", 32'(k), 32'd5);

        // Youngest match wins; rd 0 and wb 0 never hit.
        step();
        mem_ready_i = 1'b0;
        offer(32'h11, 5'd7, 1'b1);
        offer(32'h22, 5'd7, 1'b1);
        fwd_rs1_i = 5'd7;
        fwd_rs2_i = 5'd3;
        @(negedge clk);
        check("fwd_young_hit", 32'(fwd_rs1_hit_o), 32'd1);
        check("fwd_young_data", fwd_rs1_data_o, 32'h22);
        check("fwd_other_miss", 32'(fwd_rs2_hit_o), 32'd0);
        step();
        mem_ready_i = 1'b1;
        step();
        step();
        mem_ready_i = 1'b0;
        offer(32'h33, 5'd0, 1'b1);
        offer(32'h44, 5'd5, 1'b0);
        fwd_rs1_i = 5'd0;
        fwd_rs2_i = 5'd5;
        @(negedge clk);
        check("fwd_r0_miss", 32'(fwd_rs1_hit_o), 32'd0);
        check("fwd_wb0_miss", 32'(fwd_rs2_hit_o), 32'd0);

        // Flush while full with a simultaneous offer.
        step();
        flush_i     = 1'b1;
        exe_valid_i = 1'b1;
        exe_res_i   = 32'h55;
        exe_rd_i    = 5'd6;
        step();
        flush_i     = 1'b0;
        exe_valid_i = 1'b0;
        @(negedge clk);
        check("flush_empty", 32'(mem_valid_o), 32'd0);
        check("flush_ready", 32'(exe_ready_o), 32'd1);

        // Flush with one entry and an acceptable push: lookup sees old contents during flush.
        step();
        offer(32'h66, 5'd8, 1'b1);
        flush_i     = 1'b1;
        exe_valid_i = 1'b1;
        exe_res_i   = 32'h77;
        exe_rd_i    = 5'd8;
        fwd_rs1_i   = 5'd8;
        @(negedge clk);
        check("flush_fwd_hit", 32'(fwd_rs1_hit_o), 32'd1);
        check("flush_fwd_data", fwd_rs1_data_o, 32'h66);
        step();
        flush_i     = 1'b0;
        exe_valid_i = 1'b0;
        @(negedge clk);
        check("flush2_empty", 32'(mem_valid_o), 32'd0);
        check("flush2_nohit", 32'(fwd_rs1_hit_o), 32'd0);

        // Reset mid-operation while holding one entry and pushing another.
        step();
        offer(32'hAA, 5'd9, 1'b1);
        fwd_rs1_i   = 5'd9;
        exe_valid_i = 1'b1;
        exe_res_i   = 32'hBB;
        exe_rd_i    = 5'd9;
        reset       = 1'b1;
        step();
        reset       = 1'b0;
        exe_valid_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
